// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and constants for the main-RAM burst arbiter:
//               FSM state encoding, burst owner encoding, default burst
//               geometry and the cache-line alignment helper.
// Revision    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

  // Default burst geometry: 8 words per line, 32-byte lines
  localparam int c_burst_len  = 8;
  localparam int c_beat_w     = 3;
  localparam int c_line_ofs_w = 5;

  // Burst owner encoding
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // FSM state encoding
  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_ic_rd   = 3'd1;
  localparam logic [2:0] c_st_dc_rd   = 3'd2;
  localparam logic [2:0] c_st_dc_wr   = 3'd3;
  localparam logic [2:0] c_st_rd_tail = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = c_st_idle,
    IC_RD   = c_st_ic_rd,
    DC_RD   = c_st_dc_rd,
    DC_WR   = c_st_dc_wr,
    RD_TAIL = c_st_rd_tail
  } arb_state_e;

  // Clears the byte-offset-within-line bits of the default line size
  localparam logic [31:0] c_line_mask = ~((32'd1 << c_line_ofs_w) - 32'd1);

  // Aligns a byte address down to the start of its line
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int ofs_w);
    return addr & ~((32'd1 << ofs_w) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_rr2
// Description : Two-way round-robin picker. A lone requester wins outright;
//               on a tie the requester that did not win last time is chosen.
//               last_grant resets to the D-cache so the I-cache wins the
//               first tie.
// Revision    : 1.0  initial release
// ============================================================================
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_ic,
  input  logic i_req_dc,
  output logic o_grant,
  output logic o_owner
);

  logic r_last_grant;

  // Pick the winner for this cycle (only meaningful when o_grant is high)
  always_comb begin
    o_grant = i_en & (i_req_ic | i_req_dc);
    o_owner = OWN_IC;
    if (i_req_ic && i_req_dc) begin
      o_owner = ~r_last_grant;
    end else if (i_req_dc) begin
      o_owner = OWN_DC;
    end
  end

  // Remember who won the most recent grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= OWN_DC;
    end else if (o_grant) begin
      r_last_grant <= o_owner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_burst_arbiter
// Description : Shares the single-ported main RAM between the I-cache refill
//               path and the D-cache refill/writeback path. Whole line bursts
//               are granted one owner at a time with round-robin fairness.
//               RAM read latency is one cycle; read beats are returned with
//               their word index, tagged to the burst owner.
//               Optional macro RAM_ARB_PERF_EN adds saturating performance
//               counters (burst counts per requester and wait cycles).
// Revision    : 1.0  initial release
// ============================================================================
module ram_burst_arbiter
  import ram_arb_pkg::*;
#(
  parameter int BURST_LEN  = c_burst_len,
  parameter int BEAT_W     = c_beat_w,
  parameter int LINE_OFS_W = c_line_ofs_w
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  output logic              ic_rvalid,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [31:0]       dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic              dc_wready,
  output logic              dc_rvalid,
  output logic              dc_done,
  output logic [31:0]       rd_data,
  output logic [BEAT_W-1:0] rd_beat,
  output logic              ram_ren,
  output logic [3:0]        ram_wen,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_ic_bursts,
  output logic [31:0]       perf_dc_bursts,
  output logic [31:0]       perf_wait_cycles
`endif
);

  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(BURST_LEN - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [BEAT_W-1:0] r_beat;
  logic [BEAT_W-1:0] w_beat_nxt;
  logic              r_owner;
  logic [31:0]       r_base;
  logic              r_rd_pend;
  logic [BEAT_W-1:0] r_rd_beat;
  logic              w_grant;
  logic              w_owner;
  logic              w_rd_done;
  logic              w_wr_done;
  logic [31:0]       w_beat_ofs;

  // Round-robin choice, only consulted while idle
  ram_arb_rr2 u_rr2 (
    .clk      (clk),
    .rst      (rst),
    .i_en     (r_state == IDLE),
    .i_req_ic (ic_req),
    .i_req_dc (dc_req),
    .o_grant  (w_grant),
    .o_owner  (w_owner)
  );

  assign w_beat_ofs = {{(30 - BEAT_W){1'b0}}, r_beat, 2'b00};

  // Next-state and RAM port drive; the port idles at all-zero outside a burst
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    ram_ren     = 1'b0;
    ram_wen     = 4'h0;
    ram_addr    = 32'h0;
    ram_wdata   = 32'h0;
    dc_wready   = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (w_owner == OWN_IC) begin
            w_state_nxt = IC_RD;
          end else if (dc_we) begin
            w_state_nxt = DC_WR;
          end else begin
            w_state_nxt = DC_RD;
          end
        end
      end
      IC_RD, DC_RD: begin
        ram_ren    = 1'b1;
        ram_addr   = r_base + w_beat_ofs;
        w_beat_nxt = r_beat + 1'b1;
        if (r_beat == c_last_beat) begin
          w_state_nxt = RD_TAIL;
        end
      end
      DC_WR: begin
        ram_wen    = 4'hF;
        dc_wready  = 1'b1;
        ram_wdata  = dc_wdata;
        ram_addr   = r_base + w_beat_ofs;
        w_beat_nxt = r_beat + 1'b1;
        if (r_beat == c_last_beat) begin
          w_wr_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      RD_TAIL: begin
        // Final read beat is returning; the burst is complete this cycle
        w_rd_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat counter; wraps to zero naturally after the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else begin
      r_beat <= w_beat_nxt;
    end
  end

  // Latch owner and line-aligned base address at grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= OWN_DC;
      r_base  <= 32'h0;
    end else if (w_grant) begin
      r_owner <= w_owner;
      r_base  <= line_align((w_owner == OWN_IC) ? ic_addr : dc_addr, LINE_OFS_W);
    end
  end

  // Track the read issued last cycle so its data can be tagged on return
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pend <= 1'b0;
      r_rd_beat <= '0;
    end else begin
      r_rd_pend <= ram_ren;
      if (ram_ren) begin
        r_rd_beat <= r_beat;
      end
    end
  end

  // Read return and completion outputs; data is zeroed when no beat returns
  always_comb begin
    ic_rvalid = r_rd_pend & (r_owner == OWN_IC);
    dc_rvalid = r_rd_pend & (r_owner == OWN_DC);
    rd_data   = r_rd_pend ? ram_rdata : 32'h0;
    rd_beat   = r_rd_pend ? r_rd_beat : '0;
    ic_done   = w_rd_done & (r_owner == OWN_IC);
    dc_done   = (w_rd_done & (r_owner == OWN_DC)) | w_wr_done;
  end

`ifdef RAM_ARB_PERF_EN
  logic w_ic_owns;
  logic w_dc_owns;
  logic w_waiting;

  // A requester owns the port during its burst and in the idle cycle it wins
  always_comb begin
    w_ic_owns = ((r_state != IDLE) && (r_owner == OWN_IC)) || (w_grant && (w_owner == OWN_IC));
    w_dc_owns = ((r_state != IDLE) && (r_owner == OWN_DC)) || (w_grant && (w_owner == OWN_DC));
    w_waiting = (ic_req && !w_ic_owns) || (dc_req && !w_dc_owns);
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ic_bursts   <= 32'h0;
      perf_dc_bursts   <= 32'h0;
      perf_wait_cycles <= 32'h0;
    end else begin
      if (ic_done && (perf_ic_bursts != 32'hFFFF_FFFF)) begin
        perf_ic_bursts <= perf_ic_bursts + 32'd1;
      end
      if (dc_done && (perf_dc_bursts != 32'hFFFF_FFFF)) begin
        perf_dc_bursts <= perf_dc_bursts + 32'd1;
      end
      if (w_waiting && (perf_wait_cycles != 32'hFFFF_FFFF)) begin
        perf_wait_cycles <= perf_wait_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_burst_arbiter
// Description : Self-checking bench for ram_burst_arbiter. A behavioural RAM
//               with one-cycle read latency sits on the RAM port; expected
//               addresses, write data and tagged read beats are queued when a
//               request is raised and popped as the DUT produces them.
//               Perf counter checks are compiled with RAM_ARB_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_burst_arbiter;

  localparam logic TB_IC = 1'b0;
  localparam logic TB_DC = 1'b1;

  logic        clk;
  logic        rst;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        dc_wready;
  logic        dc_rvalid;
  logic        dc_done;
  logic [31:0] rd_data;
  logic [2:0]  rd_beat;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
`ifdef RAM_ARB_PERF_EN
  logic [31:0] perf_ic_bursts;
  logic [31:0] perf_dc_bursts;
  logic [31:0] perf_wait_cycles;
`endif

  ram_burst_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rvalid (ic_rvalid),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_wready (dc_wready),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .rd_data   (rd_data),
    .rd_beat   (rd_beat),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef RAM_ARB_PERF_EN
    ,
    .perf_ic_bursts   (perf_ic_bursts),
    .perf_dc_bursts   (perf_dc_bursts),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] addr_q[$];
  logic [31:0] wd_q[$];
  logic [35:0] rd_q[$];   // {owner, beat, data}

  logic [31:0] mem    [4096];
  logic [31:0] shadow [4096];

  int ic_beats    = 0;
  int dc_rbeats   = 0;
  int dc_wbeats   = 0;
  int ic_done_cnt = 0;
  int dc_done_cnt = 0;
  int both_cnt    = 0;

  logic [31:0] wb_base;
  int          wb_idx;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i >= 32'h800 && i < 32'h808) return 32'hA0 + 32'(i - 32'h800);
    return 32'h5A00_0000 ^ 32'(i);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: byte writes, registered read (one-cycle latency)
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = init_word(i);
    ram_rdata = 32'h0;
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++) begin
        if (ram_wen[b]) mem[ram_addr[13:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end
      if (ram_ren) ram_rdata = mem[ram_addr[13:2]];
    end
  end

  // Writeback data source: next word is presented after each consumed beat
  always @(posedge clk or posedge rst) begin
    if (rst) wb_idx <= 0;
    else if (dc_done) wb_idx <= 0;
    else if (dc_wready) wb_idx <= wb_idx + 1;
  end
  assign dc_wdata = wb_base + 32'(wb_idx);

  // Queue the expected addresses and tagged beats of one line read
  task automatic push_rd(input logic own, input logic [31:0] a);
    logic [31:0] base;
    logic [31:0] wa;
    base = a & 32'hFFFF_FFE0;
    for (int k = 0; k < 8; k++) begin
      wa = base + 32'(4 * k);
      addr_q.push_back(wa);
      rd_q.push_back({own, 3'(k), shadow[wa[13:2]]});
    end
  endtask

  // Queue the expected addresses and data of one line writeback
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d0);
    logic [31:0] base;
    logic [31:0] wa;
    base = a & 32'hFFFF_FFE0;
    for (int k = 0; k < 8; k++) begin
      wa = base + 32'(4 * k);
      addr_q.push_back(wa);
      wd_q.push_back(d0 + 32'(k));
      shadow[wa[13:2]] = d0 + 32'(k);
    end
  endtask

  // Wait (bounded) for a done pulse; returns cycles elapsed
  task automatic wait_done(input bit want_ic, input bit drop, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      lat++;
      if (want_ic ? ic_done : dc_done) begin
        seen = 1'b1;
        if (drop) begin
          if (want_ic) ic_req = 1'b0;
          else dc_req = 1'b0;
        end
      end
    end
    if (!seen) begin
      check_val(want_ic ? "ic_done_seen" : "dc_done_seen", 64'(seen), 64'd1);
      ic_req = 1'b0;
      dc_req = 1'b0;
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [35:0] e;
    logic [31:0] a;
    if (!rst) begin
      if (ram_ren && (ram_wen != 4'h0)) both_cnt++;
      if (ram_ren || (ram_wen != 4'h0)) begin
        if (addr_q.size() == 0) begin
          check_val("unexp_access", 64'(addr_q.size()), 64'd1);
        end else begin
          a = addr_q.pop_front();
          check_val("ram_addr", 64'(ram_addr), 64'(a));
        end
      end
      if (dc_wready) begin
        dc_wbeats++;
        check_val("ram_wen", 64'(ram_wen), 64'hF);
        if (wd_q.size() == 0) begin
          check_val("unexp_write", 64'(wd_q.size()), 64'd1);
        end else begin
          a = wd_q.pop_front();
          check_val("ram_wdata", 64'(ram_wdata), 64'(a));
        end
      end
      if (ic_rvalid || dc_rvalid) begin
        if (ic_rvalid) ic_beats++;
        else dc_rbeats++;
        if (rd_q.size() == 0) begin
          check_val("unexp_rvalid", 64'(rd_q.size()), 64'd1);
        end else begin
          e = rd_q.pop_front();
          check_val("rd_owner", 64'({ic_rvalid, dc_rvalid}), (e[35] == TB_IC) ? 64'd2 : 64'd1);
          check_val("rd_beat", 64'(rd_beat), 64'(e[34:32]));
          check_val("rd_data", 64'(rd_data), 64'(e[31:0]));
        end
      end
      if (ic_done) begin
        check_val("ic_done_beats", 64'(ic_beats), 64'd8);
        check_val("ic_done_last", 64'({ic_rvalid, rd_beat}), 64'hF);
        ic_beats = 0;
        ic_done_cnt++;
      end
      if (dc_done) begin
        check_val("dc_done_beats", 64'(dc_rbeats + dc_wbeats), 64'd8);
        dc_rbeats = 0;
        dc_wbeats = 0;
        dc_done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int gap;
    int done_before;
    bit hit;
    for (int i = 0; i < 4096; i++) shadow[i] = init_word(i);
    rst = 1'b1;
    ic_req = 1'b0; ic_addr = 32'h0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = 32'h0;
    wb_base = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", 64'({ic_rvalid, ic_done, dc_wready, dc_rvalid, dc_done, ram_ren, ram_wen, rd_beat}), 64'd0);
    check_val("rst_addr", 64'(ram_addr), 64'd0);
    check_val("rst_wdata", 64'(ram_wdata), 64'd0);
    check_val("rst_rdata", 64'(rd_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // I-cache alone, unaligned address
    push_rd(TB_IC, 32'h0000_1234);
    ic_addr = 32'h0000_1234; ic_req = 1'b1;
    wait_done(1'b1, 1'b1, lat);
    check_val("ic_lat", 64'(lat), 64'd9);
    repeat (3) @(negedge clk);

    // D-cache refill, writeback, re-read of the same line
    push_rd(TB_DC, 32'h0000_2000);
    dc_addr = 32'h0000_2000; dc_we = 1'b0; dc_req = 1'b1;
    wait_done(1'b0, 1'b1, lat);
    check_val("dc_rd_lat", 64'(lat), 64'd9);
    repeat (3) @(negedge clk);
    push_wr(32'h0000_2000, 32'hB0);
    wb_base = 32'hB0; dc_we = 1'b1; dc_req = 1'b1;
    wait_done(1'b0, 1'b1, lat);
    dc_we = 1'b0;
    check_val("dc_wr_lat", 64'(lat), 64'd8);
    repeat (3) @(negedge clk);
    push_rd(TB_DC, 32'h0000_2000);
    dc_req = 1'b1;
    wait_done(1'b0, 1'b1, lat);
    repeat (3) @(negedge clk);

    // Contention: IC first, then DC, then IC again
    push_rd(TB_IC, 32'h0000_1100);
    push_rd(TB_DC, 32'h0000_2000);
    ic_addr = 32'h0000_1100; dc_addr = 32'h0000_2000;
    ic_req = 1'b1; dc_req = 1'b1;
    wait_done(1'b1, 1'b0, lat);
    check_val("contest_ic_lat", 64'(lat), 64'd9);
    push_rd(TB_IC, 32'h0000_1340);
    ic_addr = 32'h0000_1340;
    wait_done(1'b0, 1'b1, lat);
    check_val("contest_dc_lat", 64'(lat), 64'd10);
    wait_done(1'b1, 1'b1, lat);
    check_val("contest_ic2_lat", 64'(lat), 64'd10);
    repeat (3) @(negedge clk);
`ifdef RAM_ARB_PERF_EN
    check_val("perf_ic", 64'(perf_ic_bursts), 64'd3);
    check_val("perf_dc", 64'(perf_dc_bursts), 64'd4);
    check_val("perf_wait", 64'(perf_wait_cycles), 64'd20);
`endif

    // Back-to-back I-cache bursts: one idle cycle between them
    push_rd(TB_IC, 32'h0000_1400);
    ic_addr = 32'h0000_1400; ic_req = 1'b1;
    wait_done(1'b1, 1'b0, lat);
    push_rd(TB_IC, 32'h0000_1420);
    ic_addr = 32'h0000_1420;
    gap = 0; hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      @(negedge clk);
      gap++;
      if (ram_ren) hit = 1'b1;
    end
    check_val("b2b_gap", 64'(gap), 64'd2);
    wait_done(1'b1, 1'b1, lat);
    check_val("b2b_lat", 64'(lat), 64'd8);
    repeat (3) @(negedge clk);

    // Reset in the middle of a writeback (during beat 4)
    push_wr(32'h0000_3000, 32'hD0);
    wb_base = 32'hD0; dc_addr = 32'h0000_3000; dc_we = 1'b1; dc_req = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(negedge clk);
      if (dc_wready && ram_addr == 32'h0000_3010) hit = 1'b1;
    end
    check_val("rst_beat4_seen", 64'(hit), 64'd1);
    done_before = dc_done_cnt;
    #2 rst = 1'b1;
    #1;
    check_val("midrst_ctrl", 64'({ic_rvalid, ic_done, dc_wready, dc_rvalid, dc_done, ram_ren, ram_wen, rd_beat}), 64'd0);
    check_val("midrst_addr", 64'(ram_addr), 64'd0);
    check_val("midrst_wdata", 64'(ram_wdata), 64'd0);
`ifdef RAM_ARB_PERF_EN
    check_val("perf_clr", 64'({perf_ic_bursts, perf_wait_cycles}), 64'd0);
`endif
    dc_req = 1'b0; dc_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    addr_q.delete();
    wd_q.delete();
    dc_wbeats = 0; dc_rbeats = 0; ic_beats = 0;
    repeat (2) @(negedge clk);
    check_val("midrst_no_done", 64'(dc_done_cnt), 64'(done_before));

    // Fresh grant after reset starts at beat 0
    push_rd(TB_DC, 32'h0000_2004);
    dc_addr = 32'h0000_2004; dc_req = 1'b1;
    wait_done(1'b0, 1'b1, lat);
    check_val("post_rst_lat", 64'(lat), 64'd9);
    repeat (3) @(negedge clk);

    check_val("addr_q_left", 64'(addr_q.size()), 64'd0);
    check_val("wd_q_left", 64'(wd_q.size()), 64'd0);
    check_val("rd_q_left", 64'(rd_q.size()), 64'd0);
    check_val("ren_wen_both", 64'(both_cnt), 64'd0);
    check_val("ic_done_cnt", 64'(ic_done_cnt), 64'd5);
    check_val("dc_done_cnt", 64'(dc_done_cnt), 64'd5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
